// File: rtl/pixel_sensor_row_if.sv
// Control and readout bundle between the array sequencer and one sensor row.
// The sequencer drives the phase strobes and COUNTER, and the row returns DATA_OUT.
interface pixel_sensor_row_if #(
    parameter int unsigned PIXEL_ARRAY_WIDTH = 4,
    parameter int unsigned PIXEL_BITS        = 8
);
    logic                                          VBN1;
    logic                                          RAMP;
    logic                                          ERASE;
    logic                                          EXPOSE;
    logic                                          READ;
    logic [PIXEL_BITS-1:0]                         COUNTER;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]  DATA_OUT;

    modport master (
        output VBN1, RAMP, ERASE, EXPOSE, READ, COUNTER,
        input  DATA_OUT
    );

    modport slave (
        input  VBN1, RAMP, ERASE, EXPOSE, READ, COUNTER,
        output DATA_OUT
    );
endinterface

// File: rtl/pixel_sensor_row.sv
// One row of integrating pixels sharing a single-slope ADC ramp.
// Each pixel latches COUNTER until the shared ramp passes its integrated value.
module pixel_sensor_row #(
    parameter int unsigned PIXEL_ARRAY_WIDTH = 4,
    parameter int unsigned PIXEL_BITS        = 8,
    parameter int unsigned V_BITS            = 16,
    parameter int unsigned DV_BASE           = 64,
    parameter int unsigned DV_STEP           = 64,
    parameter int unsigned RAMP_STEP         = 256
) (
    input  logic               clk,
    input  logic               reset,
    pixel_sensor_row_if.slave  bus
);
    localparam int unsigned W  = PIXEL_ARRAY_WIDTH;
    localparam int unsigned VW = V_BITS + 1;
    localparam logic [V_BITS-1:0] V_MAX = '1;

    typedef enum logic [1:0] {
        PH_HOLD,
        PH_ERASE,
        PH_EXPOSE,
        PH_CONVERT
    } phase_e;

    logic [V_BITS-1:0]              v_q     [W];
    logic [V_BITS-1:0]              v_d     [W];
    logic [VW-1:0]                  v_sum   [W];
    logic [W-1:0]                   tripped_q, tripped_d;
    logic [W-1:0][PIXEL_BITS-1:0]   mem_q, mem_d;
    logic [V_BITS-1:0]              ramp_q, ramp_d;
    logic [VW-1:0]                  ramp_sum;
    phase_e                         phase_c;

    // Phase decode with ERASE > EXPOSE > conversion priority.
    always_comb begin
        phase_c = PH_HOLD;
        if (bus.ERASE) begin
            phase_c = PH_ERASE;
        end else if (bus.EXPOSE) begin
            phase_c = PH_EXPOSE;
        end else if (bus.RAMP) begin
            phase_c = PH_CONVERT;
        end
    end

    // Saturating adders: exposure increment grows linearly with column index.
    always_comb begin
        ramp_sum = {1'b0, ramp_q} + VW'(RAMP_STEP);
        for (int i = 0; i < int'(W); i++) begin
            v_sum[i] = {1'b0, v_q[i]} + VW'(DV_BASE + 32'(i) * DV_STEP);
        end
    end

    always_comb begin
        v_d       = v_q;
        tripped_d = tripped_q;
        mem_d     = mem_q;
        ramp_d    = ramp_q;
        unique case (phase_c)
            PH_ERASE: begin
                for (int i = 0; i < int'(W); i++) begin
                    v_d[i] = '0;
                end
                tripped_d = '0;
                ramp_d    = '0;
            end
            PH_EXPOSE: begin
                if (bus.VBN1) begin
                    for (int i = 0; i < int'(W); i++) begin
                        v_d[i] = v_sum[i][V_BITS] ? V_MAX : v_sum[i][V_BITS-1:0];
                    end
                end
                tripped_d = '0;
                ramp_d    = '0;
            end
            PH_CONVERT: begin
                // A pixel keeps tracking COUNTER until the ramp first exceeds it.
                for (int i = 0; i < int'(W); i++) begin
                    if (!tripped_q[i]) begin
                        if (ramp_q > v_q[i]) begin
                            tripped_d[i] = 1'b1;
                        end else begin
                            mem_d[i] = bus.COUNTER;
                        end
                    end
                end
                ramp_d = ramp_sum[V_BITS] ? V_MAX : ramp_sum[V_BITS-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(W); i++) begin
                v_q[i] <= '0;
            end
            tripped_q <= '0;
            mem_q     <= '0;
            ramp_q    <= '0;
        end else begin
            for (int i = 0; i < int'(W); i++) begin
                v_q[i] <= v_d[i];
            end
            tripped_q <= tripped_d;
            mem_q     <= mem_d;
            ramp_q    <= ramp_d;
        end
    end

    // Zero-latency readout gate.
    always_comb begin
        bus.DATA_OUT = '0;
        if (bus.READ) begin
            bus.DATA_OUT = mem_q;
        end
    end

endmodule

// File: tb/tb_pixel_sensor_row.sv
// Randomized self-checking bench for pixel_sensor_row against an arithmetic model.
// Directed phases reproduce the known codes, then random phases are compared each cycle.
module tb_pixel_sensor_row;
    localparam int unsigned W  = 4;
    localparam int unsigned PB = 8;
    localparam int unsigned VB = 16;
    localparam int unsigned VMAX = 65535;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_sensor_row_if #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_BITS(PB)) bus ();

    pixel_sensor_row #(
        .PIXEL_ARRAY_WIDTH(W), .PIXEL_BITS(PB), .V_BITS(VB),
        .DV_BASE(64), .DV_STEP(64), .RAMP_STEP(256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_v    [W];
    int unsigned m_mem  [W];
    bit          m_trip [W];
    int unsigned m_ramp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: photo charge grows 64*(col+1) per exposed cycle, a pixel keeps the code
    // of the last ramp step not above its charge.
    task automatic model_step(input bit r, input bit e, input bit x, input bit vb,
                              input bit rp, input int unsigned cnt);
        if (r) begin
            m_ramp = 0;
            foreach (m_v[i]) begin m_v[i] = 0; m_mem[i] = 0; m_trip[i] = 0; end
        end else if (e) begin
            m_ramp = 0;
            foreach (m_v[i]) begin m_v[i] = 0; m_trip[i] = 0; end
        end else if (x) begin
            m_ramp = 0;
            foreach (m_v[i]) begin
                m_trip[i] = 0;
                if (vb) m_v[i] = (m_v[i] + 64 * (i + 1) > VMAX) ? VMAX : m_v[i] + 64 * (i + 1);
            end
        end else if (rp) begin
            foreach (m_v[i]) begin
                if (!m_trip[i]) begin
                    if (m_ramp > m_v[i]) m_trip[i] = 1;
                    else                 m_mem[i]  = cnt;
                end
            end
            m_ramp = (m_ramp + 256 > VMAX) ? VMAX : m_ramp + 256;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit x, input bit vb,
                         input bit rp, input int unsigned cnt, input bit rd);
        reset       = r;
        bus.ERASE   = e;
        bus.EXPOSE  = x;
        bus.VBN1    = vb;
        bus.RAMP    = rp;
        bus.COUNTER = PB'(cnt);
        bus.READ    = rd;
        @(posedge clk);
        model_step(r, e, x, vb, rp, cnt);
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < int'(W); i++) begin
            check_eq($sformatf("%s_px%0d", tag, i), 32'(bus.DATA_OUT[i]),
                     bus.READ ? m_mem[i] : 0);
        end
    endtask

    task automatic check_codes(input string tag, input int unsigned c0, input int unsigned c1,
                               input int unsigned c2, input int unsigned c3);
        int unsigned exp [W];
        exp = '{c0, c1, c2, c3};
        bus.READ = 1'b1;
        #1;
        for (int i = 0; i < int'(W); i++) begin
            check_eq($sformatf("%s_px%0d", tag, i), 32'(bus.DATA_OUT[i]), exp[i]);
        end
    endtask

    task automatic erase(input int unsigned n);
        for (int k = 0; k < int'(n); k++) cycle(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic expose(input int unsigned n);
        for (int k = 0; k < int'(n); k++) cycle(0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic convert(input int unsigned n);
        for (int k = 0; k < int'(n); k++) cycle(0, 0, 0, 0, 1, k, 0);
    endtask

    initial begin
        int unsigned on_left;
        bit vb;

        // Reset with READ high, then an erase burst.
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        check_codes("reset", 0, 0, 0, 0);
        erase(5);
        check_codes("post_erase", 0, 0, 0, 0);

        // Full erase/expose/convert cycle.
        erase(5);
        expose(255);
        convert(256);
        check_codes("full", 63, 127, 191, 255);
        check_model("full_model");

        // Exposure gating: exactly 100 of 255 exposure cycles have VBN1 high.
        erase(5);
        on_left = 100;
        for (int c = 0; c < 255; c++) begin
            vb = (on_left > 0) && ($urandom_range(254 - c, 0) < on_left);
            if (vb) on_left--;
            cycle(0, 0, 1, vb, 0, 0, 0);
        end
        convert(256);
        check_codes("gating", 25, 50, 75, 100);

        // Saturation: charge clips at full scale and every pixel tracks to the end.
        erase(5);
        expose(2000);
        convert(256);
        check_codes("saturate", 255, 255, 255, 255);
        bus.READ = 1'b0;
        #1;
        check_codes("read_low_saturated", 255, 255, 255, 255);
        bus.READ = 1'b0;
        #1;
        for (int i = 0; i < int'(W); i++)
            check_eq($sformatf("read_gate_px%0d", i), 32'(bus.DATA_OUT[i]), 0);

        // ERASE wins over EXPOSE, so every pixel holds zero charge.
        for (int k = 0; k < 10; k++) cycle(0, 1, 1, 1, 0, 0, 0);
        convert(256);
        check_codes("priority", 0, 0, 0, 0);

        // Reset in the middle of conversion, then a clean full cycle.
        erase(5);
        expose(255);
        convert(30);
        cycle(1, 0, 0, 0, 1, 30, 0);
        check_codes("mid_conv_reset", 0, 0, 0, 0);
        erase(5);
        expose(255);
        convert(256);
        check_codes("after_reset_full", 63, 127, 191, 255);

        // Random phase sequences compared against the model every cycle.
        for (int blk = 0; blk < 24; blk++) begin
            int unsigned ph, len;
            ph  = $urandom_range(3, 0);
            len = $urandom_range(ph == 3 ? 260 : 120, 1);
            for (int k = 0; k < int'(len); k++) begin
                bit r, e, x, rp;
                r  = ($urandom_range(399, 0) == 0);
                e  = (ph == 0);
                x  = (ph == 1) || (ph == 0 && $urandom_range(1, 0) == 1);
                rp = (ph == 3) || ($urandom_range(3, 0) == 0);
                cycle(r, e, x, $urandom_range(3, 0) != 0, rp, $urandom_range(255, 0),
                      $urandom_range(1, 0) == 1);
                check_model("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_sensor_row.md
Name: pixel_sensor_row

Overview:
- Cycle-based digital model of one row of PIXEL_ARRAY_WIDTH image-sensor pixels with a shared single-slope ADC.
- Each pixel integrates a photo value during exposure and is then compared against a shared ramp during conversion.
- During conversion each pixel captures the externally supplied digital COUNTER value; capture stops once the ramp exceeds the pixel value.
- Sits between the sensor-array control state machine (ERASE/EXPOSE/convert/READ phases) and the row readout bus.

Parameters:
- PIXEL_ARRAY_WIDTH, 4, number of pixels (columns) in the row.
- PIXEL_BITS, 8, width of COUNTER and of each pixel's stored code.
- V_BITS, 16, width of each pixel's integration accumulator and of the ramp accumulator.
- DV_BASE, 64, per-cycle exposure increment of pixel 0.
- DV_STEP, 64, extra increment per column index; pixel i gains DV_BASE + i*DV_STEP per exposure cycle.
- RAMP_STEP, 256, per-cycle ramp increment during conversion.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- VBN1  input  1  bias/exposure enable; pixels integrate only while EXPOSE && VBN1.
- RAMP  input  1  ramp-advance enable; a conversion cycle occurs while RAMP && !ERASE && !EXPOSE.
- ERASE  input  1  clear pixel accumulators, comparator flags and ramp.
- EXPOSE  input  1  exposure phase.
- READ  input  1  readout enable for DATA_OUT.
- COUNTER  input  PIXEL_BITS  digital ramp code, captured by pixels during conversion.
- DATA_OUT  output  PIXEL_ARRAY_WIDTH x PIXEL_BITS  packed array; element i is pixel i's stored code.

Behaviour:
- Per-pixel state: v[i] (V_BITS), tripped[i] (1 bit), mem[i] (PIXEL_BITS). Shared state: ramp (V_BITS).
- Reset (clk edge with reset=1): all v, ramp, mem and tripped cleared to 0. Reset has priority over every other input.
- Priority when not in reset, evaluated each rising clk edge: ERASE > EXPOSE > conversion. Lower-priority actions are ignored in that cycle.
- ERASE=1:
  - v[i] <= 0, tripped[i] <= 0, ramp <= 0.
  - mem[i] is retained.
- EXPOSE=1 (ERASE=0):
  - If VBN1=1: v[i] <= min(v[i] + DV_BASE + i*DV_STEP, 2^V_BITS-1), i.e. saturating, no wrap.
  - If VBN1=0: v holds.
  - ramp <= 0 and tripped[i] <= 0 in either case.
- Conversion cycle (RAMP=1, ERASE=0, EXPOSE=0), evaluated per pixel using pre-edge values:
  - If tripped[i]=0 and ramp > v[i]: tripped[i] <= 1; mem[i] unchanged.
  - If tripped[i]=0 and ramp <= v[i]: mem[i] <= COUNTER.
  - If tripped[i]=1: no change.
  - Then ramp <= min(ramp + RAMP_STEP, 2^V_BITS-1), saturating.
- A pixel whose v is never exceeded keeps tracking COUNTER every conversion cycle.
- Result: with COUNTER=k on the k-th conversion cycle (k from 0), mem[i] = floor(v[i]/RAMP_STEP).
- RAMP=0 and no ERASE/EXPOSE: all state holds. v is never modified by READ or conversion.
- DATA_OUT is combinational: element i = mem[i] when READ=1, else all zeros. Zero latency; READ has no effect on internal state.
- READ may be asserted during any phase; it shows current mem, including values mid-conversion.
- Reset mid-exposure or mid-conversion: all state cleared on that edge. DATA_OUT then reads 0 when READ=1.
- No handshakes. Sequencing (erase -> expose -> convert -> read) is the controller's responsibility.

Test Plan:
- Reset: hold reset 2 cycles with READ=1 -> DATA_OUT all zeros. Release, pulse ERASE 5 cycles -> DATA_OUT still 0.
- Full cycle: ERASE 5 cycles; EXPOSE+VBN1 for 255 cycles (v = 16320, 32640, 48960, 65280); 256 conversion cycles with COUNTER=k on cycle k; READ -> DATA_OUT = {63, 127, 191, 255} for pixels 0..3.
- Exposure gating: EXPOSE 255 cycles with VBN1 high only on 100 of them -> v[0]=6400. After conversion with COUNTER=k, mem[0]=25.
- Saturation: EXPOSE+VBN1 for 2000 cycles -> every v = 65535, no wrap. Conversion -> every pixel captures 255, the last COUNTER value driven.
- Priority: ERASE and EXPOSE high together for 10 cycles, then conversion with COUNTER=k -> every v=0, mem[i]=0 (trips on cycle 1, captures only k=0). READ=0 during readout phase -> DATA_OUT all zeros regardless of mem.
- Reset mid-conversion: assert reset at conversion cycle 30 -> next READ gives all zeros. A subsequent full cycle reproduces {63, 127, 191, 255}.
